// File: rtl/fire_control_if.sv
// fire_control_if: fire key, ship/aim inputs and rate-limited shot outputs
// between the input front end and the bullet spawner.
interface fire_control_if;
    logic       fire_key;
    logic [7:0] ship_x;
    logic [6:0] ship_y;
    logic [1:0] dir_x;
    logic [1:0] dir_y;
    logic       bullet_retired;
    logic       pressed;
    logic [7:0] shot_x;
    logic [6:0] shot_y;
    logic [1:0] shot_dir_x;
    logic [1:0] shot_dir_y;
    logic       shot_denied;
    logic [7:0] live_count;
    logic       cooling;

    modport master (
        output fire_key, ship_x, ship_y, dir_x, dir_y, bullet_retired,
        input  pressed, shot_x, shot_y, shot_dir_x, shot_dir_y, shot_denied, live_count, cooling
    );
    modport slave (
        input  fire_key, ship_x, ship_y, dir_x, dir_y, bullet_retired,
        output pressed, shot_x, shot_y, shot_dir_x, shot_dir_y, shot_denied, live_count, cooling
    );
endinterface

// File: rtl/fire_control.sv
// fire_control: debounced, rate-limited fire strobe with latched launch data
// and a live-bullet cap for the bullet spawner.
module fire_control #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] COOLDOWN_CYCLES = 24'd5000000,
    parameter logic [7:0]  MAX_LIVE        = 8'd160
) (
    input  logic          clk,
    input  logic          reset,
    fire_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_t;

    state_t      r_state;
    logic [1:0]  r_sync;
    logic [1:0]  r_boot;
    logic        r_armed;
    logic        r_deb_level;
    logic        r_deb_prev;
    logic        r_rise;
    logic [15:0] r_cnt;
    logic [23:0] r_ccnt;
    logic [7:0]  r_live;
    logic        r_pressed;
    logic        r_denied;
    logic        r_cooling;
    logic [7:0]  r_shot_x;
    logic [6:0]  r_shot_y;
    logic [1:0]  r_shot_dir_x;
    logic [1:0]  r_shot_dir_y;

    logic w_key_s;
    logic w_aim_ok;
    logic w_inc;

    assign w_key_s  = r_sync[1];
    // 01 and 10 have odd parity; 00 and reserved 11 count as no aim
    assign w_aim_ok = (^bus.dir_x) | (^bus.dir_y);
    assign w_inc    = r_state == FIRE;

    assign bus.pressed     = r_pressed;
    assign bus.shot_x      = r_shot_x;
    assign bus.shot_y      = r_shot_y;
    assign bus.shot_dir_x  = r_shot_dir_x;
    assign bus.shot_dir_y  = r_shot_dir_y;
    assign bus.shot_denied = r_denied;
    assign bus.live_count  = r_live;
    assign bus.cooling     = r_cooling;

    // Arming needs the synchroniser to carry a real low sample, so a key held
    // through reset release cannot produce a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync      <= '0;
            r_boot      <= '0;
            r_armed     <= 1'b0;
            r_deb_level <= 1'b0;
            r_deb_prev  <= 1'b0;
            r_rise      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync     <= {r_sync[0], bus.fire_key};
            r_boot     <= r_boot[1] ? r_boot : r_boot + 2'd1;
            r_armed    <= r_armed | (r_boot[1] & ~w_key_s);
            r_deb_prev <= r_deb_level;
            r_rise     <= r_deb_level & ~r_deb_prev & r_armed;
            if (w_key_s == r_deb_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                r_deb_level <= w_key_s;
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live <= '0;
        end else if (w_inc != bus.bullet_retired) begin
            r_live <= w_inc ? r_live + 8'd1 : (r_live != 8'd0 ? r_live - 8'd1 : r_live);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ccnt       <= '0;
            r_pressed    <= 1'b0;
            r_denied     <= 1'b0;
            r_cooling    <= 1'b0;
            r_shot_x     <= '0;
            r_shot_y     <= '0;
            r_shot_dir_x <= '0;
            r_shot_dir_y <= '0;
        end else begin
            r_pressed <= 1'b0;
            r_denied  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_rise) begin
                        if (r_live < MAX_LIVE && w_aim_ok) begin
                            r_state      <= FIRE;
                            r_pressed    <= 1'b1;
                            r_shot_x     <= bus.ship_x;
                            r_shot_y     <= bus.ship_y;
                            r_shot_dir_x <= bus.dir_x;
                            r_shot_dir_y <= bus.dir_y;
                        end else begin
                            r_denied <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    if (COOLDOWN_CYCLES == 24'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= COOLDOWN;
                        r_ccnt    <= COOLDOWN_CYCLES - 24'd1;
                        r_cooling <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (r_ccnt == 24'd0) begin
                        r_state   <= IDLE;
                        r_cooling <= 1'b0;
                    end else begin
                        r_ccnt <= r_ccnt - 24'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fire_control.sv
// tb_fire_control: directed and randomized presses checked every cycle against
// an event-level model of acceptance, cooldown window and live count.
module tb_fire_control;
    localparam int D = 4;
    localparam int C = 10;
    localparam int M = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    fire_control_if bus();

    fire_control #(
        .DEBOUNCE_CYCLES(16'd4),
        .COOLDOWN_CYCLES(24'd10),
        .MAX_LIVE(8'd3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_live;
    int m_fire;
    int m_rise_at;
    logic m_pressed;
    logic m_denied;
    logic [18:0] m_shot;
    logic ret_on_fire = 1'b0;
    logic rand_ret = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        m_live    = 0;
        m_fire    = -100;
        m_rise_at = -1;
        m_pressed = 1'b0;
        m_denied  = 1'b0;
        m_shot    = '0;
    endtask

    function automatic logic aim(input logic [1:0] d);
        return d == 2'b01 || d == 2'b10;
    endfunction

    // Accepted key rises act on the 8th edge after first sample; a fire is
    // allowed only once FIRE (1 cycle) and COOLDOWN (C cycles) have elapsed.
    task automatic step();
        logic fired, ret;
        fired = m_pressed;
        ret   = bus.bullet_retired;
        @(posedge clk);
        cyc++;
        m_pressed = 1'b0;
        m_denied  = 1'b0;
        if (!reset) begin
            model_clear();
        end else begin
            if (cyc == m_rise_at && cyc >= m_fire + C + 2) begin
                if (m_live < M && (aim(bus.dir_x) || aim(bus.dir_y))) begin
                    m_pressed = 1'b1;
                    m_fire    = cyc;
                    m_shot    = {bus.ship_x, bus.ship_y, bus.dir_x, bus.dir_y};
                end else begin
                    m_denied = 1'b1;
                end
            end
            if (fired && !ret) m_live++;
            else if (!fired && ret && m_live > 0) m_live--;
        end
        #1;
        chk("pressed", 32'(bus.pressed), 32'(m_pressed));
        chk("shot_denied", 32'(bus.shot_denied), 32'(m_denied));
        chk("cooling", 32'(bus.cooling), 32'(cyc >= m_fire + 1 && cyc <= m_fire + C));
        chk("live_count", 32'(bus.live_count), 32'(m_live));
        chk("shot", 32'({bus.shot_x, bus.shot_y, bus.shot_dir_x, bus.shot_dir_y}), 32'(m_shot));
        bus.bullet_retired = ret_on_fire ? m_pressed : (rand_ret ? ($urandom_range(0, 3) == 0) : 1'b0);
    endtask

    task automatic press(input int h, input int l, input logic [7:0] sx, input logic [6:0] sy,
                         input logic [1:0] dx, input logic [1:0] dy);
        bus.ship_x   = sx;
        bus.ship_y   = sy;
        bus.dir_x    = dx;
        bus.dir_y    = dy;
        bus.fire_key = 1'b1;
        if (h >= D) m_rise_at = cyc + 8;
        repeat (h) step();
        bus.fire_key = 1'b0;
        repeat (l) step();
    endtask

    task automatic retire();
        bus.bullet_retired = 1'b1;
        step();
    endtask

    function automatic logic [7:0] rx();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [6:0] ry();
        return 7'($urandom_range(0, 127));
    endfunction

    initial begin
        bus.fire_key       = 1'b0;
        bus.ship_x         = '0;
        bus.ship_y         = '0;
        bus.dir_x          = '0;
        bus.dir_y          = '0;
        bus.bullet_retired = 1'b0;
        model_clear();
        repeat (3) step();
        reset = 1'b1;
        repeat (6) step();
        // single long press with known launch data
        press(50, 10, 8'd40, 7'd30, 2'b01, 2'b00);
        // 3-cycle glitch must not be accepted
        press(3, 8, rx(), ry(), 2'b10, 2'b01);
        // second press lands in cooldown and is dropped; third fires
        press(5, 5, rx(), ry(), 2'b01, 2'b01);
        press(5, 5, rx(), ry(), 2'b10, 2'b00);
        press(6, 8, rx(), ry(), 2'b00, 2'b10);
        // drain to zero, extra retirement must not underflow
        repeat (4) retire();
        // live cap: three fire, the fourth is denied
        repeat (4) press(6, 8, rx(), ry(), 2'b10, 2'b10);
        retire();
        press(6, 8, rx(), ry(), 2'b01, 2'b10);
        repeat (3) retire();
        // no aim, coincident retire, reserved encoding
        press(6, 8, rx(), ry(), 2'b00, 2'b00);
        press(6, 8, rx(), ry(), 2'b01, 2'b00);
        ret_on_fire = 1'b1;
        press(6, 8, rx(), ry(), 2'b00, 2'b10);
        ret_on_fire = 1'b0;
        press(6, 8, rx(), ry(), 2'b11, 2'b00);
        press(6, 8, rx(), ry(), 2'b11, 2'b01);
        repeat (3) retire();
        // randomized presses, glitches and retirements
        rand_ret = 1'b1;
        repeat (16) press($urandom_range(1, 8), $urandom_range(5, 14), rx(), ry(),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        rand_ret = 1'b0;
        repeat (15) step();
        repeat (3) retire();
        // reset during cooldown with key held
        bus.ship_x   = rx();
        bus.ship_y   = ry();
        bus.dir_x    = 2'b01;
        bus.dir_y    = 2'b00;
        bus.fire_key = 1'b1;
        m_rise_at    = cyc + 8;
        repeat (12) step();
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("async_reset", 32'({bus.pressed, bus.shot_denied, bus.cooling, bus.live_count,
                                bus.shot_x, bus.shot_y, bus.shot_dir_x, bus.shot_dir_y}), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        repeat (30) step();
        bus.fire_key = 1'b0;
        repeat (8) step();
        press(6, 8, rx(), ry(), 2'b10, 2'b01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
